// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C controller.
// The I2C_CLOCK_STRETCH_EN build option changes only the controller and bit timer, not this package.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_COND,
    ADDR_TX,
    ADDR_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    READ_NACK,
    STOP_COND
  } i2c_ctrl_state_t;

  // Command latched from the host on accept.
  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
  } i2c_cmd_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam int unsigned BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_bit_timer.sv
// Quarter-period counter: 2-bit phase (q0..q3), quarter_tick at the end of each quarter,
// bit_done at the end of q3. hold (used by I2C_CLOCK_STRETCH_EN) pins the count at 0.
module i2c_bit_timer #(
  parameter int unsigned DIV_QTR = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       hold,
  output logic [1:0] phase,
  output logic       quarter_tick,
  output logic       bit_done
);

  localparam int unsigned CNT_W = (DIV_QTR > 1) ? $clog2(DIV_QTR) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_QTR - 1);

  logic [CNT_W-1:0] cnt;

  assign quarter_tick = run && !hold && (cnt == CNT_MAX);
  assign bit_done     = quarter_tick && (phase == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (hold) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: START, address, one data byte (write or read), STOP.
// Define I2C_CLOCK_STRETCH_EN to let a subordinate stretch SCL during q1.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_QTR = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        SCL,
  inout  wire        SDA,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic [7:0] rdata,
  output logic       done,
  output logic       ack_error
);

  i2c_ctrl_state_t state;
  i2c_cmd_t        cmd;
  logic [7:0]      shreg;
  logic [2:0]      bit_cnt;
  logic            scl_low, sda_low;
  logic            scl_low_c, sda_low_c;
  logic [1:0]      sda_sync;
  logic            ack_sample;
  logic [1:0]      phase;
  logic            quarter_tick, bit_done, hold, run, sample_c;

  assign SCL = scl_low ? 1'b0 : 1'bz;
  assign SDA = sda_low ? 1'b0 : 1'bz;

  assign run      = (state != IDLE);
  assign sample_c = quarter_tick && (phase == 2'd2);

`ifdef I2C_CLOCK_STRETCH_EN
  logic [1:0] scl_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl_sync <= 2'b00;
    else        scl_sync <= {scl_sync[0], SCL};
  end

  // Wait in q1 until the released SCL is actually seen high on the bus.
  assign hold = (phase == 2'd1) && !scl_sync[1];
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sda_sync <= 2'b11;
    else        sda_sync <= {sda_sync[0], SDA};
  end

  i2c_bit_timer #(.DIV_QTR(DIV_QTR)) u_bit_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .hold         (hold),
    .phase        (phase),
    .quarter_tick (quarter_tick),
    .bit_done     (bit_done)
  );

  // Line levels for the current state/quarter; registered below before reaching the pads.
  always_comb begin
    scl_low_c = 1'b0;
    sda_low_c = 1'b0;
    case (state)
      IDLE: ;
      START_COND: begin
        scl_low_c = (phase == 2'd3);
        sda_low_c = (phase >= 2'd2);
      end
      ADDR_TX, WRITE_DATA: begin
        scl_low_c = (phase == 2'd0) || (phase == 2'd3);
        sda_low_c = !shreg[7];
      end
      STOP_COND: begin
        scl_low_c = (phase == 2'd0);
        sda_low_c = (phase != 2'd3);
      end
      default: scl_low_c = (phase == 2'd0) || (phase == 2'd3);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= '0;
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
      scl_low    <= 1'b0;
      sda_low    <= 1'b0;
      ack_sample <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 8'h00;
      ack_error  <= 1'b0;
    end else begin
      done    <= 1'b0;
      scl_low <= scl_low_c;
      sda_low <= sda_low_c;
      if (sample_c) ack_sample <= sda_sync[1];
      case (state)
        IDLE: begin
          // busy is only still set here in the done cycle, where start is ignored.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            cmd       <= '{rw: rw, addr: addr, wdata: wdata};
            shreg     <= {addr, rw};
            bit_cnt   <= 3'd0;
            ack_error <= 1'b0;
            busy      <= 1'b1;
            state     <= START_COND;
          end
        end
        START_COND: if (bit_done) state <= ADDR_TX;
        ADDR_TX, WRITE_DATA: begin
          if (bit_done) begin
            shreg   <= {shreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(BITS_PER_BYTE - 1))
              state <= (state == ADDR_TX) ? ADDR_ACK : WRITE_ACK;
          end
        end
        ADDR_ACK: begin
          if (bit_done) begin
            if (ack_sample == I2C_NACK) begin
              ack_error <= 1'b1;
              state     <= STOP_COND;
            end else if (cmd.rw == RW_READ) begin
              state <= READ_DATA;
            end else begin
              shreg <= cmd.wdata;
              state <= WRITE_DATA;
            end
          end
        end
        WRITE_ACK: begin
          if (bit_done) begin
            if (ack_sample == I2C_NACK) ack_error <= 1'b1;
            state <= STOP_COND;
          end
        end
        READ_DATA: begin
          if (sample_c) shreg <= {shreg[6:0], sda_sync[1]};
          if (bit_done) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) state <= READ_NACK;
          end
        end
        READ_NACK: if (bit_done) state <= STOP_COND;
        STOP_COND: begin
          if (bit_done) begin
            done  <= 1'b1;
            state <= IDLE;
            if (cmd.rw == RW_READ && !ack_error) rdata <= shreg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
